// File: rtl/integer_loader_if.sv
// Byte-stream handshake used to feed the integer loader, plus the enum type
// shared between the loader and the integer-types top it drives.
package integer_loader_pkg;
    typedef enum int {A = 0, B = 1, C = 45, D = 123789} enum_e;
endpackage

interface integer_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/integer_loader.sv
// Assembles [selector, payload LE] frames from a byte stream and commits each
// one atomically to the matching integer-typed output register.
module integer_loader
    import integer_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    integer_loader_if.slave   s,
    output enum_e             enum_output,
    output byte               byte_output,
    output shortint           shortint_output,
    output int                int_output,
    output longint            longint_output,
    output integer            integer_output,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [15:0] TIMEOUT = TIMEOUT_CYCLES[15:0];

    logic [1:0]  state;
    logic [2:0]  sel;
    logic [63:0] shreg;
    logic [3:0]  cnt;
    logic [15:0] idle_cnt;
    logic [15:0] idle_nxt;
    logic [3:0]  last_idx;
    logic        accept;
    logic        timeout_hit;
    logic        enum_legal;

    assign s.s_ready   = (state != COMMIT);
    assign busy        = (state != IDLE);
    assign accept      = s.s_valid && s.s_ready;
    assign idle_nxt    = idle_cnt + 16'd1;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (idle_nxt == TIMEOUT);
    assign enum_legal  = (shreg[31:0] == 32'd0)  || (shreg[31:0] == 32'd1) ||
                         (shreg[31:0] == 32'd45) || (shreg[31:0] == 32'd123789);

    // Index of the final payload byte for the latched selector.
    always_comb begin
        last_idx = 4'd3;
        case (sel)
            3'd1:    last_idx = 4'd0;
            3'd2:    last_idx = 4'd1;
            3'd4:    last_idx = 4'd7;
            default: last_idx = 4'd3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            sel             <= 3'd0;
            shreg           <= 64'd0;
            cnt             <= 4'd0;
            idle_cnt        <= 16'd0;
            done            <= 1'b0;
            err             <= 1'b0;
            enum_output     <= A;
            byte_output     <= 8'sd0;
            shortint_output <= 16'sd0;
            int_output      <= 32'sd0;
            longint_output  <= 64'sd0;
            integer_output  <= 32'sd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (s.s_data <= 8'd5) begin
                            sel      <= s.s_data[2:0];
                            shreg    <= 64'd0;
                            cnt      <= 4'd0;
                            idle_cnt <= 16'd0;
                            state    <= LOAD;
                        end else if (s.s_data == 8'd6) begin
                            sel   <= 3'd6;
                            state <= COMMIT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shreg[{cnt[2:0], 3'b000} +: 8] <= s.s_data;
                        cnt      <= cnt + 4'd1;
                        idle_cnt <= 16'd0;
                        if (cnt == last_idx)
                            state <= COMMIT;
                    end else if (timeout_hit) begin
                        // Partial frame is dropped; outputs keep their values.
                        err      <= 1'b1;
                        idle_cnt <= 16'd0;
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_nxt;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    case (sel)
                        3'd0: begin
                            if (enum_legal) begin
                                enum_output <= enum_e'(shreg[31:0]);
                                done        <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        3'd1: begin byte_output     <= shreg[7:0];  done <= 1'b1; end
                        3'd2: begin shortint_output <= shreg[15:0]; done <= 1'b1; end
                        3'd3: begin int_output      <= shreg[31:0]; done <= 1'b1; end
                        3'd4: begin longint_output  <= shreg;       done <= 1'b1; end
                        3'd5: begin integer_output  <= shreg[31:0]; done <= 1'b1; end
                        default: begin
                            enum_output     <= A;
                            byte_output     <= 8'sd0;
                            shortint_output <= 16'sd0;
                            int_output      <= 32'sd0;
                            longint_output  <= 64'sd0;
                            integer_output  <= 32'sd0;
                            done            <= 1'b1;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_integer_loader.sv
// Directed-vector bench for integer_loader with hand-computed expectations.
module tb_integer_loader;
    import integer_loader_pkg::*;

    logic    clk;
    logic    rst_n;
    enum_e   enum_output;
    byte     byte_output;
    shortint shortint_output;
    int      int_output;
    longint  longint_output;
    integer  integer_output;
    logic    busy, done, err;

    int errors = 0;
    int checks = 0;

    integer_loader_if ifc ();

    integer_loader #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s               (ifc.slave),
        .enum_output     (enum_output),
        .byte_output     (byte_output),
        .shortint_output (shortint_output),
        .int_output      (int_output),
        .longint_output  (longint_output),
        .integer_output  (integer_output),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a byte and hold it until it transfers; returns 1 time unit after that edge.
    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        ifc.s_data  = b;
        ifc.s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (ifc.s_ready) break;
            n++;
            if (n > 20) begin
                $display("FAIL push: s_ready stuck low, got 0 expected 1");
                $fatal(1, "handshake stalled");
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        ifc.s_data  = 8'h00;
        ifc.s_valid = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_ready", 64'(ifc.s_ready), 64'd1);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_err",   64'(err),  64'd0);
        chk("rst_enum",  64'(int'(enum_output)), 64'd0);
        chk("rst_long",  longint_output, 64'd0);

        // int frame
        push(8'd3); push(8'h78); push(8'h56); push(8'h34); push(8'h12);
        ifc.s_valid = 1'b0;
        chk("int_commit_ready", 64'(ifc.s_ready), 64'd0);
        chk("int_early_done",   64'(done), 64'd0);
        step();
        chk("int_done",  64'(done), 64'd1);
        chk("int_val",   64'(int_output), 64'h0000_0000_1234_5678);
        chk("int_other", 64'(byte_output), 64'd0);
        step();
        chk("int_done_pulse", 64'(done), 64'd0);

        // back-to-back byte then longint, valid held high
        push(8'd1); push(8'h80);
        chk("byte_commit_ready", 64'(ifc.s_ready), 64'd0);
        push(8'd4);
        chk("byte_val", byte_output, -64'sd128);
        for (int i = 0; i < 8; i++) push(8'hFF);
        ifc.s_valid = 1'b0;
        chk("long_commit_ready", 64'(ifc.s_ready), 64'd0);
        step();
        chk("long_ready_back", 64'(ifc.s_ready), 64'd1);
        chk("long_done", 64'(done), 64'd1);
        chk("long_val",  longint_output, 64'hFFFF_FFFF_FFFF_FFFF);

        // enum legal then illegal
        push(8'd0); push(8'h8D); push(8'hE3); push(8'h01); push(8'h00);
        ifc.s_valid = 1'b0;
        step();
        chk("enum_done", 64'(done), 64'd1);
        chk("enum_val",  64'(int'(enum_output)), 64'd123789);
        push(8'd0); push(8'h02); push(8'h00); push(8'h00); push(8'h00);
        ifc.s_valid = 1'b0;
        step();
        chk("enum_bad_err",  64'(err), 64'd1);
        chk("enum_bad_done", 64'(done), 64'd0);
        chk("enum_bad_keep", 64'(int'(enum_output)), 64'd123789);

        // illegal selector
        push(8'h2A);
        ifc.s_valid = 1'b0;
        chk("illegal_err",  64'(err), 64'd1);
        chk("illegal_busy", 64'(busy), 64'd0);
        step();
        chk("illegal_err_pulse", 64'(err), 64'd0);
        push(8'd2); push(8'h34); push(8'h12);
        ifc.s_valid = 1'b0;
        step();
        chk("short_val", 64'(shortint_output), 64'h1234);

        // timeout after four idle cycles
        push(8'd5); push(8'hAA);
        ifc.s_valid = 1'b0;
        n = 0;
        while (n < 10 && !err) begin
            step();
            n++;
        end
        chk("to_cycles",  64'(n), 64'd4);
        chk("to_busy",    64'(busy), 64'd0);
        chk("to_integer", 64'(integer_output), 64'd0);
        push(8'd5); push(8'h01); push(8'h00); push(8'h00); push(8'h00);
        ifc.s_valid = 1'b0;
        step();
        chk("integer_val", 64'(integer_output), 64'd1);

        // reset in the middle of a longint frame
        push(8'd4); push(8'h01); push(8'h02); push(8'h03);
        ifc.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_enum",  64'(int'(enum_output)), 64'd0);
        chk("arst_byte",  64'(byte_output), 64'd0);
        chk("arst_short", 64'(shortint_output), 64'd0);
        chk("arst_int",   64'(int_output), 64'd0);
        chk("arst_long",  longint_output, 64'd0);
        chk("arst_integ", 64'(integer_output), 64'd0);
        chk("arst_busy",  64'(busy), 64'd0);
        step();
        rst_n = 1'b1;

        // reload a field, then clear-all
        push(8'd1); push(8'h05);
        ifc.s_valid = 1'b0;
        step();
        chk("reload_byte", 64'(byte_output), 64'd5);
        push(8'd6);
        ifc.s_valid = 1'b0;
        chk("clear_ready", 64'(ifc.s_ready), 64'd0);
        step();
        chk("clear_done", 64'(done), 64'd1);
        chk("clear_byte", 64'(byte_output), 64'd0);
        chk("clear_enum", 64'(int'(enum_output)), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
